// File: rtl/reg_bank_seq_if.sv
// reg_bank_seq_if: bundles the decoder-side command handshake and the reg_bank-side
// select/strobe signals driven by the register-bank sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_dst/cmd_src/cmd_hl : decoded command handshake
//   done/err                                          : completion pulses to the decoder
//   ip_sel/ip_reg_sel/rtr_sel/hl_sel                  : reg_bank write source/destination selects
//   reg_wr/reg_wr_ack                                 : write strobe and its acknowledge
//   reg_clr/reg_clr_sel                               : clear strobe and target
//   pc_incr                                           : PC increment strobe
// Modports: slave = sequencer view, master = environment (decoder + reg_bank) view.
interface reg_bank_seq_if #(
  parameter int unsigned SEL_W = 9
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [SEL_W-2:0]   cmd_dst;
  logic [SEL_W-2:0]   cmd_src;
  logic [1:0]         cmd_hl;
  logic               reg_wr_ack;
  logic [2:0]         ip_sel;
  logic [SEL_W-1:0]   ip_reg_sel;
  logic [SEL_W-1:0]   rtr_sel;
  logic [1:0]         hl_sel;
  logic               reg_wr;
  logic               reg_clr;
  logic [SEL_W-1:0]   reg_clr_sel;
  logic               pc_incr;
  logic               done;
  logic               err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_hl, reg_wr_ack,
    output cmd_ready, ip_sel, ip_reg_sel, rtr_sel, hl_sel, reg_wr, reg_clr, reg_clr_sel,
           pc_incr, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_hl, reg_wr_ack,
    input  cmd_ready, ip_sel, ip_reg_sel, rtr_sel, hl_sel, reg_wr, reg_clr, reg_clr_sel,
           pc_incr, done, err
  );
endinterface

// File: rtl/reg_bank_seq.sv
// reg_bank_seq: control-side driver for reg_bank. Accepts one decoded register command per
// handshake, sequences reg_bank's select/strobe inputs, closes the reg_wr/reg_wr_ack handshake
// with a timeout and reports done/err pulses back to the decoder.
// Ports:
//   clk    : clock, all state on the rising edge
//   rst    : asynchronous active-high reset
//   bus_io : reg_bank_seq_if.slave (command handshake, reg_bank selects/strobes, done/err)
// Optional feature: define REG_BANK_SEQ_AUTO_PC_EN to route every successful WR_*/CLR through
// one pc_incr pulse before DONE.
module reg_bank_seq #(
  parameter int unsigned SEL_W       = 9,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input logic            clk,
  input logic            rst,
  reg_bank_seq_if.slave  bus_io
);

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpWrRtr = 3'd1;
  localparam logic [2:0] OpWrAlu = 3'd2;
  localparam logic [2:0] OpWrDib = 3'd3;
  localparam logic [2:0] OpWrImm = 3'd4;
  localparam logic [2:0] OpClr   = 3'd5;
  localparam logic [2:0] OpPcInc = 3'd6;
  localparam logic [2:0] OpRsvd  = 3'd7;

  // MSB set = no register selected.
  localparam logic [SEL_W-1:0] SelIdle = {1'b1, {(SEL_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StSetup, StWrite, StClear, StPcinc, StDone, StErr
  } state_e;

`ifdef REG_BANK_SEQ_AUTO_PC_EN
  localparam state_e StPostOp = StPcinc;
`else
  localparam state_e StPostOp = StDone;
`endif

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [SEL_W-2:0]  dst_q, dst_d;
  logic [SEL_W-2:0]  src_q, src_d;
  logic [1:0]        hl_q, hl_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpNop;
      dst_q   <= '0;
      src_q   <= '0;
      hl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      hl_q    <= hl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    hl_d    = hl_q;
    case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          op_d  = bus_io.cmd_op;
          dst_d = bus_io.cmd_dst;
          src_d = bus_io.cmd_src;
          hl_d  = bus_io.cmd_hl;
          case (bus_io.cmd_op)
            OpNop:   state_d = StDone;
            OpRsvd:  state_d = StErr;
            OpPcInc: state_d = StPcinc;
            default: state_d = StSetup;
          endcase
        end
      end
      StSetup: state_d = (op_q == OpClr) ? StClear : StWrite;
      StWrite: begin
        cnt_d = cnt_q + 1'b1;
        // Ack takes priority over a coincident timeout.
        if (bus_io.reg_wr_ack) begin
          state_d = StPostOp;
        end else if (cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          state_d = StErr;
        end
      end
      StClear: state_d = StPostOp;
      StPcinc: state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_io.cmd_ready   = (state_q == StIdle);
    bus_io.ip_sel      = 3'd0;
    bus_io.ip_reg_sel  = SelIdle;
    bus_io.rtr_sel     = SelIdle;
    bus_io.hl_sel      = 2'd0;
    bus_io.reg_clr_sel = SelIdle;
    bus_io.reg_wr      = (state_q == StWrite);
    bus_io.reg_clr     = (state_q == StClear);
    bus_io.pc_incr     = (state_q == StPcinc);
    bus_io.done        = (state_q == StDone);
    bus_io.err         = (state_q == StErr);

    if (state_q == StSetup || state_q == StWrite) begin
      case (op_q)
        OpWrRtr: begin
          bus_io.ip_sel     = 3'd1;
          bus_io.ip_reg_sel = {1'b0, dst_q};
          bus_io.rtr_sel    = {1'b0, src_q};
        end
        OpWrAlu: begin
          bus_io.ip_sel     = 3'd2;
          bus_io.ip_reg_sel = {1'b0, dst_q};
        end
        OpWrDib: begin
          bus_io.ip_sel     = 3'd3;
          bus_io.ip_reg_sel = {1'b0, dst_q};
        end
        OpWrImm: begin
          bus_io.ip_sel     = 3'd4;
          bus_io.ip_reg_sel = {1'b0, dst_q};
          bus_io.hl_sel     = hl_q;
        end
        default: ;
      endcase
    end

    if ((state_q == StSetup || state_q == StClear) && op_q == OpClr) begin
      bus_io.reg_clr_sel = {1'b0, dst_q};
    end
  end

endmodule

// File: tb/tb_reg_bank_seq.sv
// tb_reg_bank_seq: directed self-checking bench for reg_bank_seq with hand-computed
// expectations. Define REG_BANK_SEQ_AUTO_PC_EN for both bench and RTL to check the auto-PC build.
module tb_reg_bank_seq;

  localparam logic [8:0] SelIdle = 9'h100;
`ifdef REG_BANK_SEQ_AUTO_PC_EN
  localparam int AutoPc = 1;
`else
  localparam int AutoPc = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Per-command observations collected by run_cmd.
  int         wr_n, clr_n, pc_n, done_n, err_n, fin_at, ready_at;
  logic [2:0] cap_ip_sel;
  logic [8:0] cap_ip_reg_sel, cap_rtr_sel, cap_clr_sel;
  logic [1:0] cap_hl;
  logic       idle_ok, ready_seen;

  reg_bank_seq_if #(.SEL_W(9)) bus_if ();

  reg_bank_seq #(
    .SEL_W       (9),
    .ACK_TIMEOUT (16),
    .TO_W        (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, then follow it until cmd_ready returns (bounded), acking the write
  // in its ack_at-th WRITE cycle (0 = never ack).
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] dst, input logic [7:0] src,
                         input logic [1:0] hl, input int ack_at);
    wr_n = 0; clr_n = 0; pc_n = 0; done_n = 0; err_n = 0; fin_at = 0; ready_at = 0;
    cap_ip_sel = '0; cap_ip_reg_sel = '0; cap_rtr_sel = '0; cap_clr_sel = '0; cap_hl = '0;
    idle_ok = 1'b1; ready_seen = 1'b0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_dst   = dst;
    bus_if.cmd_src   = src;
    bus_if.cmd_hl    = hl;
    tick();
    // Fields must be ignored after acceptance.
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_dst   = 8'hff;
    bus_if.cmd_src   = 8'hff;
    bus_if.cmd_hl    = 2'd3;
    for (int c = 1; c <= 40; c++) begin
      if (bus_if.cmd_ready) begin
        ready_seen = 1'b1;
        ready_at   = c;
        break;
      end
      if (bus_if.reg_wr) begin
        wr_n++;
        cap_ip_sel     = bus_if.ip_sel;
        cap_ip_reg_sel = bus_if.ip_reg_sel;
        cap_rtr_sel    = bus_if.rtr_sel;
        cap_hl         = bus_if.hl_sel;
      end
      if (bus_if.reg_clr) begin
        clr_n++;
        cap_clr_sel = bus_if.reg_clr_sel;
      end
      if (bus_if.pc_incr) pc_n++;
      if (bus_if.done || bus_if.err) begin
        if (bus_if.done) done_n++;
        if (bus_if.err) err_n++;
        fin_at = c;
        if (bus_if.ip_sel != 3'd0 || bus_if.ip_reg_sel != SelIdle || bus_if.rtr_sel != SelIdle ||
            bus_if.reg_clr_sel != SelIdle || bus_if.hl_sel != 2'd0 || bus_if.reg_wr ||
            bus_if.reg_clr || bus_if.pc_incr) idle_ok = 1'b0;
      end
      bus_if.reg_wr_ack = (ack_at > 0) && bus_if.reg_wr && (wr_n == ack_at);
      tick();
    end
    bus_if.reg_wr_ack = 1'b0;
    check_eq("cmd_returns_idle", {31'd0, ready_seen}, 32'd1);
  endtask

  initial begin
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_op     = 3'd0;
    bus_if.cmd_dst    = 8'd0;
    bus_if.cmd_src    = 8'd0;
    bus_if.cmd_hl     = 2'd0;
    bus_if.reg_wr_ack = 1'b0;

    // Async reset applied before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_eq("rst_cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
    check_eq("rst_ip_sel", {29'd0, bus_if.ip_sel}, 32'd0);
    check_eq("rst_ip_reg_sel", {23'd0, bus_if.ip_reg_sel}, 32'h100);
    check_eq("rst_rtr_sel", {23'd0, bus_if.rtr_sel}, 32'h100);
    check_eq("rst_clr_sel", {23'd0, bus_if.reg_clr_sel}, 32'h100);
    check_eq("rst_strobes", {27'd0, bus_if.reg_wr, bus_if.reg_clr, bus_if.pc_incr, bus_if.done,
                             bus_if.err}, 32'd0);
    tick();
    #3 rst = 1'b0;
    tick();

    // 1: reset mid-WRITE abandons the write with no done/err.
    bus_if.cmd_valid = 1'b1; bus_if.cmd_op = 3'd3; bus_if.cmd_dst = 8'd5;
    tick();
    bus_if.cmd_valid = 1'b0;
    tick();
    check_eq("t1_in_write", {31'd0, bus_if.reg_wr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t1_async_reg_wr", {31'd0, bus_if.reg_wr}, 32'd0);
    check_eq("t1_async_ip_reg_sel", {23'd0, bus_if.ip_reg_sel}, 32'h100);
    check_eq("t1_async_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
    check_eq("t1_async_done_err", {30'd0, bus_if.done, bus_if.err}, 32'd0);
    tick();
    check_eq("t1_held_done_err", {30'd0, bus_if.done, bus_if.err}, 32'd0);
    #3 rst = 1'b0;
    tick();
    check_eq("t1_after_done_err", {30'd0, bus_if.done, bus_if.err}, 32'd0);

    // 2: WR_ALU dst=0, ack in 2nd WRITE cycle.
    run_cmd(3'd2, 8'd0, 8'd0, 2'd0, 2);
    check_eq("t2_ip_sel", {29'd0, cap_ip_sel}, 32'd2);
    check_eq("t2_ip_reg_sel", {23'd0, cap_ip_reg_sel}, 32'h000);
    check_eq("t2_wr_cycles", wr_n, 32'd2);
    check_eq("t2_done_n", done_n, 32'd1);
    check_eq("t2_done_at", fin_at, 32'(4 + AutoPc));
    check_eq("t2_ready_at", ready_at, 32'(5 + AutoPc));
    check_eq("t2_pc_n", pc_n, 32'(AutoPc));
    check_eq("t2_idle_ok", {31'd0, idle_ok}, 32'd1);

    // 3: WR_RTR dst=3 src=1, then WR_IMM dst=2 hl=1.
    run_cmd(3'd1, 8'd3, 8'd1, 2'd0, 1);
    check_eq("t3a_ip_sel", {29'd0, cap_ip_sel}, 32'd1);
    check_eq("t3a_rtr_sel", {23'd0, cap_rtr_sel}, 32'h001);
    check_eq("t3a_ip_reg_sel", {23'd0, cap_ip_reg_sel}, 32'h003);
    check_eq("t3a_done_n", done_n, 32'd1);
    check_eq("t3a_done_at", fin_at, 32'(3 + AutoPc));
    run_cmd(3'd4, 8'd2, 8'd7, 2'd1, 1);
    check_eq("t3b_ip_sel", {29'd0, cap_ip_sel}, 32'd4);
    check_eq("t3b_hl_sel", {30'd0, cap_hl}, 32'd1);
    check_eq("t3b_ip_reg_sel", {23'd0, cap_ip_reg_sel}, 32'h002);
    check_eq("t3b_rtr_sel_idle", {23'd0, cap_rtr_sel}, 32'h100);
    check_eq("t3b_done_n", done_n, 32'd1);

    // 4: WR_DIB never acked -> 16 write cycles then err.
    run_cmd(3'd3, 8'd4, 8'd0, 2'd0, 0);
    check_eq("t4_wr_cycles", wr_n, 32'd16);
    check_eq("t4_err_n", err_n, 32'd1);
    check_eq("t4_done_n", done_n, 32'd0);
    check_eq("t4_err_at", fin_at, 32'd18);
    check_eq("t4_pc_n", pc_n, 32'd0);
    check_eq("t4_idle_ok", {31'd0, idle_ok}, 32'd1);

    // 5: CLR dst=2, PCINC, reserved op, NOP.
    run_cmd(3'd5, 8'd2, 8'd0, 2'd0, 0);
    check_eq("t5_clr_n", clr_n, 32'd1);
    check_eq("t5_clr_sel", {23'd0, cap_clr_sel}, 32'h002);
    check_eq("t5_clr_wr_n", wr_n, 32'd0);
    check_eq("t5_clr_done_at", fin_at, 32'(3 + AutoPc));
    check_eq("t5_clr_pc_n", pc_n, 32'(AutoPc));
    run_cmd(3'd6, 8'd0, 8'd0, 2'd0, 0);
    check_eq("t5_pc_n", pc_n, 32'd1);
    check_eq("t5_pc_done_at", fin_at, 32'd2);
    check_eq("t5_pc_done_n", done_n, 32'd1);
    run_cmd(3'd7, 8'd1, 8'd1, 2'd1, 0);
    check_eq("t5_rsvd_err_n", err_n, 32'd1);
    check_eq("t5_rsvd_err_at", fin_at, 32'd1);
    check_eq("t5_rsvd_strobes", wr_n + clr_n + pc_n + done_n, 32'd0);
    run_cmd(3'd0, 8'd0, 8'd0, 2'd0, 0);
    check_eq("t5_nop_done_at", fin_at, 32'd1);
    check_eq("t5_nop_done_n", done_n, 32'd1);

    // Ack while idle is ignored.
    bus_if.reg_wr_ack = 1'b1;
    tick();
    tick();
    check_eq("ack_idle_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
    check_eq("ack_idle_err", {30'd0, bus_if.err, bus_if.done}, 32'd0);
    bus_if.reg_wr_ack = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
